rvj1_bus_arbiter: RTL



---
 rtl/rvj1_bus_arbiter_pkg.sv | 17 +
 rtl/rvj1_id_fifo.sv | 59 +++++
 rtl/rvj1_bus_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rvj1_bus_arbiter_pkg.sv
// Shared widths and ID types for the rvj1 bus arbiter and its outstanding-ID FIFO.
package rvj1_bus_arbiter_pkg;

  localparam int XLEN                  = 32;
  localparam int NBYTES                = XLEN / 8;
  localparam int NCH_MAX               = 8;
  localparam int ARB_MAX_OUTST_DEFAULT = 4;

  typedef logic [$clog2(NCH_MAX)-1:0] arb_id_t;

  // Next channel after id, wrapping at nch (nch == 1 always yields 0).
  function automatic arb_id_t arb_next_id(arb_id_t id, int nch);
    if (int'(id) >= nch - 1) return '0;
    return id + arb_id_t'(1);
  endfunction

endpackage

// File: rtl/rvj1_id_fifo.sv
// Synchronous FIFO with full/empty/count; pushes while full and pops while empty are ignored.
module rvj1_id_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Flags come from the registered count, so a pop frees a slot only next cycle.
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rvj1_bus_arbiter.sv
// N-channel req/rsp arbiter onto one memory port with in-order response routing.
// Define RVJ1_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rvj1_bus_arbiter
  import rvj1_bus_arbiter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int MAX_OUTST = ARB_MAX_OUTST_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NCH*XLEN-1:0]   ch_req_addr_i,
  input  logic [NCH*XLEN-1:0]   ch_req_data_i,
  input  logic [NCH*NBYTES-1:0] ch_req_strobe_i,
  input  logic [NCH-1:0]        ch_req_write_i,
  input  logic [NCH-1:0]        ch_req_valid_i,
  output logic [NCH-1:0]        ch_req_ready_o,
  output logic [NCH*XLEN-1:0]   ch_rsp_data_o,
  output logic [NCH-1:0]        ch_rsp_error_o,
  output logic [NCH-1:0]        ch_rsp_valid_o,
  input  logic [NCH-1:0]        ch_rsp_ready_i,
  output logic [XLEN-1:0]       mem_req_addr_o,
  output logic [XLEN-1:0]       mem_req_data_o,
  output logic [NBYTES-1:0]     mem_req_strobe_o,
  output logic                  mem_req_write_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [XLEN-1:0]       mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o
  ,output logic                 spurious_rsp_o
);

  // Handshake rule on every port: a transfer happens in a cycle where valid && ready.

  localparam int CW = $clog2(MAX_OUTST) + 1;

  arb_id_t       scan_id, sel_id, head_id, lock_id_q, lock_id_d;
  logic          scan_found, sel_valid, head_rdy;
  logic          lock_q, lock_d, spurious_q, spurious_d;
  logic          fifo_full, fifo_empty, req_hs, rsp_hs;
  logic [CW-1:0] fifo_cnt;
  logic          unused_cnt;

`ifndef RVJ1_ARB_FIXED_PRIO_EN
  arb_id_t ptr_q, ptr_d;
`endif

  always_comb begin
    scan_found = 1'b0;
    scan_id    = '0;
`ifdef RVJ1_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NCH; i++) begin
      if (!scan_found && ch_req_valid_i[i]) begin
        scan_found = 1'b1;
        scan_id    = arb_id_t'(i);
      end
    end
`else
    // Offset i from the pointer maps to channel k either directly or after one wrap.
    for (int i = 0; i < NCH; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!scan_found && ch_req_valid_i[k] &&
            ((int'(ptr_q) + i == k) || (int'(ptr_q) + i == k + NCH))) begin
          scan_found = 1'b1;
          scan_id    = arb_id_t'(k);
        end
      end
    end
`endif
  end

  assign sel_id = lock_q ? lock_id_q : scan_id;

  always_comb begin
    mem_req_addr_o   = '0;
    mem_req_data_o   = '0;
    mem_req_strobe_o = '0;
    mem_req_write_o  = 1'b0;
    sel_valid        = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_id == arb_id_t'(k)) begin
        mem_req_addr_o   = ch_req_addr_i[k*XLEN +: XLEN];
        mem_req_data_o   = ch_req_data_i[k*XLEN +: XLEN];
        mem_req_strobe_o = ch_req_strobe_i[k*NBYTES +: NBYTES];
        mem_req_write_o  = ch_req_write_i[k];
        sel_valid        = ch_req_valid_i[k];
      end
    end
  end

  assign mem_req_valid_o = !rst_i && sel_valid && !fifo_full;
  assign req_hs          = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    ch_req_ready_o = '0;
    ch_rsp_valid_o = '0;
    head_rdy       = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_id == arb_id_t'(k)) ch_req_ready_o[k] = req_hs;
      if (head_id == arb_id_t'(k)) begin
        ch_rsp_valid_o[k] = !rst_i && mem_rsp_valid_i && !fifo_empty;
        head_rdy          = ch_rsp_ready_i[k];
      end
    end
  end

  // With nothing outstanding, any response is accepted and dropped.
  assign mem_rsp_ready_o = !rst_i && (fifo_empty ? mem_rsp_valid_i : head_rdy);
  assign rsp_hs          = !fifo_empty && mem_rsp_valid_i && mem_rsp_ready_o;
  assign spurious_d      = !rst_i && fifo_empty && mem_rsp_valid_i;
  assign spurious_rsp_o  = spurious_q;
  assign ch_rsp_data_o   = {NCH{mem_rsp_data_i}};
  assign ch_rsp_error_o  = {NCH{mem_rsp_error_i}};
  assign unused_cnt      = ^fifo_cnt;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (req_hs) begin
      lock_d = 1'b0;
    end else if (mem_req_valid_o && !mem_req_ready_i) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end
  end

`ifndef RVJ1_ARB_FIXED_PRIO_EN
  assign ptr_d = req_hs ? arb_next_id(sel_id, NCH) : ptr_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      spurious_q <= 1'b0;
`ifndef RVJ1_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      spurious_q <= spurious_d;
`ifndef RVJ1_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  rvj1_id_fifo #(
    .WIDTH($bits(arb_id_t)),
    .DEPTH(MAX_OUTST)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_hs),
    .push_data_i (sel_id),
    .pop_i       (rsp_hs),
    .pop_data_o  (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

endmodule
